out_port_arbiter: RTL and testbench
===================================

# out_port_arbiter

Per-output-port round-robin arbiter sitting directly downstream of the router input buffers. Inspects the head flit of every input buffer, selects one buffer whose head targets this output port, pops it, and forwards the flit to the next hop's input buffer. Credit-based flow control prevents overflow of the 8-entry downstream buffer.

## Interface
Parameters:
- NUM_IN, 5, number of input buffers competing for this port (2..8)
- PORT_ID, 0, 3-bit output port index this arbiter serves
- CREDITS, 8, downstream buffer depth; initial and maximum credit count (1..15)

Ports:
- clk  input  1  clock; everything is sampled on the rising edge
- rst  input  1  reset, synchronous, active-high
- head_flit  input  23*NUM_IN  head flits; input i at [i*23 +: 23]; flit fields: [22:7] data, [6:3] address, [2:0] target
- head_valid  input  NUM_IN  bit i set when input buffer i holds at least one flit
- pop  output  NUM_IN  combinational; at most one bit set; drives the pop input of the granted buffer
- credit_in  input  1  one-cycle pulse; downstream has freed one slot
- out_flit  output  23  flit sent to the downstream buffer data input
- out_valid  output  1  drives the downstream buffer valid input
- credits  output  4  current credit count
- credit_err  output  1  sticky flag; set when a credit is returned while credits == CREDITS

## Operation
- req[i] = head_valid[i] && (head_flit[i][2:0] == PORT_ID).
- Grant is issued when at least one req bit is set and credits != 0. A credit_in arriving in the same cycle does not enable a grant that cycle.
- Round-robin selection:
  - Register ptr, range 0..NUM_IN-1, reset value 0.
  - Search order is ptr, ptr+1, …, wrapping modulo NUM_IN. The first requester found is the grant g.
  - On a grant, ptr <= (g+1) mod NUM_IN. With no grant, ptr holds.
- pop[g] = 1 in the grant cycle; all other pop bits are 0. Requests for other PORT_IDs are never popped.
- Credit counter:
  - Update: credits <= credits - grant + credit_in.
  - Grant plus credit_in in the same cycle leaves credits unchanged.
  - credit_in while credits == CREDITS with no grant: credits stays CREDITS and credit_err is set.
  - credit_err clears only on rst.
- Flit path: out_flit carries head_flit[g] unmodified (see Configuration for timing). The address and target fields pass through untouched.

## Timing
- Reset values: ptr = 0, credits = CREDITS, credit_err = 0, out_valid = 0, out_flit = 0, pop = 0.
- rst asserted mid-operation: the next edge forces all reset values. Any flit held in the output register is discarded. pop is held at 0 while rst is high.
- pop is valid in the same cycle as the request. The input buffer shifts its head at that edge, so a new head is presented the following cycle and can be granted back-to-back.
- Sustained throughput is one flit per cycle while credits remain.
- Grant-to-out_valid latency is 1 cycle with OUT_ARB_REG_OUT_EN defined, 0 cycles without it.
- A single requester with credits available is granted every cycle. ptr is still updated each grant.

## Configuration
- Macro: OUT_ARB_REG_OUT_EN
- Defined:
  - out_flit and out_valid are registered.
  - out_valid <= grant and out_flit <= head_flit[g] at the grant edge.
  - Without a grant, out_valid <= 0 and out_flit holds its last value.
- Not defined:
  - out_valid = grant and out_flit = head_flit[g] are combinational in the same cycle. out_flit = 0 when there is no grant.
  - Output reset values are the same as the registered case, because no grant occurs during reset.

## Test plan
- Reset then idle: rst high for 2 cycles with all head_valid = 0 -> credits = 8, out_valid = 0, pop = 0, credit_err = 0.
- Round-robin fairness: NUM_IN = 5, PORT_ID = 2, inputs 0, 1 and 3 continuously requesting target 2, credit_in pulsed every cycle -> grant order 0, 1, 3, 0, 1, 3; exactly one pop bit per cycle.
- Port filtering: input 0 head target = 3 and input 4 head target = 2 -> only pop[4] pulses; out_flit equals input 4's flit, e.g. 23'h1ABCD2.
- Credit exhaustion: one continuous requester and no credit_in -> exactly 8 grants, then credits = 0 and pop stays 0. One credit_in pulse -> credits = 1 next cycle and exactly one more grant.
- Simultaneous grant and credit_in with credits = 3 -> credits stays 3. credit_in at credits = 8 with no grant -> credit_err = 1 until rst.
- Mid-stream reset: rst asserted during back-to-back grants -> next cycle pop = 0, out_valid = 0, ptr = 0, credits = 8.

Source files
------------

// File: rtl/out_port_arbiter.sv
`default_nettype none
// out_port_arbiter: round-robin, credit-gated arbiter for one router output port.
// Define OUT_ARB_REG_OUT_EN to register out_flit/out_valid (one cycle grant-to-valid latency).
module out_port_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int PORT_ID = 0,
  parameter int CREDITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [23*NUM_IN-1:0]   head_flit,
  input  logic [NUM_IN-1:0]      head_valid,
  output logic [NUM_IN-1:0]      pop,
  input  logic                   credit_in,
  output logic [22:0]            out_flit,
  output logic                   out_valid,
  output logic [3:0]             credits,
  output logic                   credit_err
);

  localparam int              PW        = $clog2(NUM_IN);
  localparam logic [2:0]      c_PORT_ID = PORT_ID[2:0];
  localparam logic [PW:0]     c_NUM_IN  = NUM_IN[PW:0];
  localparam logic [PW-1:0]   c_LAST    = PW'(NUM_IN - 1);
  localparam logic [3:0]      c_CREDITS = CREDITS[3:0];

  logic [PW-1:0]     r_ptr;
  logic [3:0]        r_credits;
  logic              r_credit_err;
  logic [NUM_IN-1:0] w_req;
  logic [NUM_IN-1:0] w_onehot;
  logic [PW-1:0]     w_gidx;
  logic [PW:0]       w_idx;
  logic              w_found;
  logic              w_grant;
  logic [PW-1:0]     w_ptr_nxt;
  logic [22:0]       w_gflit;

  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      w_req[i] = head_valid[i] && (head_flit[i*23 +: 3] == c_PORT_ID);
    end
  end

  // Walk ptr, ptr+1, ... modulo NUM_IN and take the first requester.
  always_comb begin
    w_onehot = '0;
    w_gidx   = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_idx = {1'b0, r_ptr} + k[PW:0];
      if (w_idx >= c_NUM_IN) begin
        w_idx = w_idx - c_NUM_IN;
      end
      if (!w_found && w_req[w_idx[PW-1:0]]) begin
        w_found                  = 1'b1;
        w_gidx                   = w_idx[PW-1:0];
        w_onehot[w_idx[PW-1:0]]  = 1'b1;
      end
    end
  end

  // A credit arriving this cycle only counts from the next cycle on.
  assign w_grant   = w_found && (r_credits != 4'd0) && !rst;
  assign pop       = w_grant ? w_onehot : '0;
  assign w_ptr_nxt = (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;

  always_comb begin
    w_gflit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pop[i]) begin
        w_gflit = w_gflit | head_flit[i*23 +: 23];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_credits    <= c_CREDITS;
      r_credit_err <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ptr <= w_ptr_nxt;
      end
      case ({w_grant, credit_in})
        2'b10:   r_credits <= r_credits - 1'b1;
        2'b01: begin
          if (r_credits == c_CREDITS) begin
            r_credit_err <= 1'b1;
          end else begin
            r_credits <= r_credits + 1'b1;
          end
        end
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign credits    = r_credits;
  assign credit_err = r_credit_err;

`ifdef OUT_ARB_REG_OUT_EN
  logic [22:0] r_out_flit;
  logic        r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_grant;
      if (w_grant) begin
        r_out_flit <= w_gflit;
      end
    end
  end

  assign out_flit  = r_out_flit;
  assign out_valid = r_out_valid;
`else
  assign out_flit  = w_gflit;
  assign out_valid = w_grant;
`endif

endmodule
`default_nettype wire

// File: tb/tb_out_port_arbiter.sv
`default_nettype none
// tb_out_port_arbiter: table-driven vectors plus a flit scoreboard for out_port_arbiter (NUM_IN=5, PORT_ID=2).
module tb_out_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [114:0] head_flit;
  logic [4:0]   head_valid;
  logic [4:0]   pop;
  logic         credit_in;
  logic [22:0]  out_flit;
  logic         out_valid;
  logic [3:0]   credits;
  logic         credit_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [22:0] sb_q[$];
  logic prev_grant = 1'b0;

  out_port_arbiter #(.NUM_IN(5), .PORT_ID(2), .CREDITS(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .head_flit  (head_flit),
    .head_valid (head_valid),
    .pop        (pop),
    .credit_in  (credit_in),
    .out_flit   (out_flit),
    .out_valid  (out_valid),
    .credits    (credits),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [4:0]  hv;
    logic [14:0] tgt;
    logic        ci;
    logic [4:0]  ep;
    logic [3:0]  ec;
    logic        ee;
  } vec_t;

  localparam logic [14:0] A2 = {5{3'd2}};
  localparam logic [14:0] PF = {3'd2, 3'd2, 3'd2, 3'd2, 3'd3};

  vec_t tbl[42];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle right after a rising edge, check at the falling edge.
  task automatic step(input logic r, input logic [4:0] hv, input logic [114:0] fl,
                      input logic ci, input logic [4:0] ep, input logic [3:0] ec,
                      input logic ee, input string nm);
    logic exp_ov;
    logic [22:0] f;
    rst        = r;
    head_valid = hv;
    head_flit  = fl;
    credit_in  = ci;
    for (int i = 0; i < 5; i++) begin
      if (ep[i]) sb_q.push_back(fl[i*23 +: 23]);
    end
    @(negedge clk);
    chk({nm, ".pop"}, {27'd0, pop}, {27'd0, ep});
    chk({nm, ".credits"}, {28'd0, credits}, {28'd0, ec});
    chk({nm, ".credit_err"}, {31'd0, credit_err}, {31'd0, ee});
`ifdef OUT_ARB_REG_OUT_EN
    exp_ov = prev_grant;
`else
    exp_ov = (ep != 5'd0);
`endif
    chk({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s.scoreboard: got out_valid with empty queue, expected an entry", nm);
      end else begin
        f = sb_q.pop_front();
        chk({nm, ".out_flit"}, {9'd0, out_flit}, {9'd0, f});
      end
    end
`ifndef OUT_ARB_REG_OUT_EN
    else chk({nm, ".out_flit_idle"}, {9'd0, out_flit}, 32'd0);
`endif
    prev_grant = (ep != 5'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [114:0] fl;
    logic [7:0]   kb;
    logic [7:0]   ib;
    // rst  hv        tgt ci  exp_pop   cred  err
    tbl[0]  = '{1'b1, 5'b00000, A2, 1'b0, 5'b00000, 4'd8, 1'b0};
    tbl[1]  = '{1'b1, 5'b00000, A2, 1'b0, 5'b00000, 4'd8, 1'b0};
    tbl[2]  = '{1'b0, 5'b00000, A2, 1'b0, 5'b00000, 4'd8, 1'b0};
    tbl[3]  = '{1'b0, 5'b01011, A2, 1'b1, 5'b00001, 4'd8, 1'b0};
    tbl[4]  = '{1'b0, 5'b01011, A2, 1'b1, 5'b00010, 4'd8, 1'b0};
    tbl[5]  = '{1'b0, 5'b01011, A2, 1'b1, 5'b01000, 4'd8, 1'b0};
    tbl[6]  = '{1'b0, 5'b01011, A2, 1'b1, 5'b00001, 4'd8, 1'b0};
    tbl[7]  = '{1'b0, 5'b01011, A2, 1'b1, 5'b00010, 4'd8, 1'b0};
    tbl[8]  = '{1'b0, 5'b01011, A2, 1'b1, 5'b01000, 4'd8, 1'b0};
    tbl[9]  = '{1'b0, 5'b10001, PF, 1'b0, 5'b10000, 4'd8, 1'b0};
    tbl[10] = '{1'b0, 5'b10001, PF, 1'b0, 5'b10000, 4'd7, 1'b0};
    tbl[11] = '{1'b1, 5'b00010, A2, 1'b0, 5'b00000, 4'd6, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[12+k] = '{1'b0, 5'b00010, A2, 1'b0, 5'b00010, 4'(8-k), 1'b0};
    tbl[20] = '{1'b0, 5'b00010, A2, 1'b0, 5'b00000, 4'd0, 1'b0};
    tbl[21] = '{1'b0, 5'b00010, A2, 1'b1, 5'b00000, 4'd0, 1'b0};
    tbl[22] = '{1'b0, 5'b00010, A2, 1'b0, 5'b00010, 4'd1, 1'b0};
    tbl[23] = '{1'b0, 5'b00010, A2, 1'b0, 5'b00000, 4'd0, 1'b0};
    tbl[24] = '{1'b0, 5'b00000, A2, 1'b1, 5'b00000, 4'd0, 1'b0};
    tbl[25] = '{1'b0, 5'b00000, A2, 1'b1, 5'b00000, 4'd1, 1'b0};
    tbl[26] = '{1'b0, 5'b00000, A2, 1'b1, 5'b00000, 4'd2, 1'b0};
    tbl[27] = '{1'b0, 5'b00010, A2, 1'b1, 5'b00010, 4'd3, 1'b0};
    tbl[28] = '{1'b0, 5'b00010, A2, 1'b1, 5'b00010, 4'd3, 1'b0};
    for (int k = 0; k < 5; k++)
      tbl[29+k] = '{1'b0, 5'b00000, A2, 1'b1, 5'b00000, 4'(3+k), 1'b0};
    tbl[34] = '{1'b0, 5'b00000, A2, 1'b1, 5'b00000, 4'd8, 1'b0};
    tbl[35] = '{1'b0, 5'b00000, A2, 1'b0, 5'b00000, 4'd8, 1'b1};
    tbl[36] = '{1'b0, 5'b00010, A2, 1'b0, 5'b00010, 4'd8, 1'b1};
    tbl[37] = '{1'b0, 5'b01011, A2, 1'b0, 5'b01000, 4'd7, 1'b1};
    tbl[38] = '{1'b0, 5'b01011, A2, 1'b0, 5'b00001, 4'd6, 1'b1};
    tbl[39] = '{1'b1, 5'b01011, A2, 1'b0, 5'b00000, 4'd5, 1'b1};
    tbl[40] = '{1'b0, 5'b01011, A2, 1'b0, 5'b00001, 4'd8, 1'b0};
    tbl[41] = '{1'b0, 5'b01011, A2, 1'b0, 5'b00010, 4'd7, 1'b0};

    rst        = 1'b1;
    head_valid = '0;
    head_flit  = '0;
    credit_in  = 1'b0;
    @(posedge clk);
    #1;

    for (int k = 0; k < 42; k++) begin
      kb = k[7:0];
      for (int i = 0; i < 5; i++) begin
        ib = i[7:0];
        fl[i*23 +: 23] = {kb, ib ^ 8'hA5, i[3:0] + 4'd3, tbl[k].tgt[i*3 +: 3]};
      end
      step(tbl[k].r, tbl[k].hv, fl, tbl[k].ci, tbl[k].ep, tbl[k].ec, tbl[k].ee,
           $sformatf("vec%0d", k));
    end

    // Explicit flit values through the port filter; ptr is 2 here, so input 4 wins.
    fl = '0;
    fl[0 +: 23]  = 23'h0FFFF3;
    fl[92 +: 23] = 23'h1ABCD2;
    step(1'b0, 5'b10001, fl, 1'b0, 5'b10000, 4'd6, 1'b0, "filter_abcd");
    step(1'b0, 5'b00000, fl, 1'b0, 5'b00000, 4'd5, 1'b0, "drain");

    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left: got %0d pending flits, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
